// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
//
// Purpose : Groups the host/test-controller side of truth_table_sweeper in one
//           bundle. The host uses the master modport and the sweeper uses the
//           slave modport.
//
// Signals :
//   start        host -> sweeper  request a sweep (accepted only while idle)
//   abort        host -> sweeper  cancel an in-progress sweep
//   busy         sweeper -> host  high while the input vectors are being swept
//   done         sweeper -> host  one-cycle pulse when a sweep completes
//   valid        sweeper -> host  truth_table holds a complete sweep
//   truth_table  sweeper -> host  bit i = q sampled with {a,b,c,d} = i
//
// Optional (macro TRUTH_TABLE_SWEEPER_COMPARE_EN):
//   exp_table           host -> sweeper  expected table, stable start..done
//   match               sweeper -> host  valid and no mismatches
//   mismatch_cnt        sweeper -> host  number of differing entries
//   first_mismatch_idx  sweeper -> host  index of the first differing entry
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if;

   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic        valid;
   logic [15:0] truth_table;

`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
   logic [15:0] exp_table;
   logic        match;
   logic [4:0]  mismatch_cnt;
   logic [3:0]  first_mismatch_idx;

   modport master (
      output start, abort, exp_table,
      input  busy, done, valid, truth_table, match, mismatch_cnt, first_mismatch_idx
   );

   modport slave (
      input  start, abort, exp_table,
      output busy, done, valid, truth_table, match, mismatch_cnt, first_mismatch_idx
   );
`else
   modport master (
      output start, abort,
      input  busy, done, valid, truth_table
   );

   modport slave (
      input  start, abort,
      output busy, done, valid, truth_table
   );
`endif

endinterface : truth_table_sweeper_if

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Purpose : Characterizes a 4-input combinational circuit. On start it drives
//           every input combination 0..15 onto {a,b,c,d} in ascending order,
//           holds each one for SETTLE_CYCLES cycles, samples q_in once, and
//           builds a 16-bit truth table (bit i = q with {a,b,c,d} = i).
//
// Parameters :
//   SETTLE_CYCLES  cycles each vector is held before q_in is sampled (1..15)
//
// Ports :
//   clk      clock, all state updates on the rising edge
//   resetn   asynchronous active-low reset
//   host     truth_table_sweeper_if.slave (start/abort/busy/done/valid/table)
//   a,b,c,d  circuit inputs, a = bit 3 ... d = bit 0 of the vector index
//   q_in     circuit output being characterized
//
// Optional feature : define TRUTH_TABLE_SWEEPER_COMPARE_EN to compare each
//   sample against host.exp_table and report match / mismatch_cnt /
//   first_mismatch_idx. Without it that logic and those signals are absent.
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   truth_table_sweeper_if.slave   host,
   output logic                   a,
   output logic                   b,
   output logic                   c,
   output logic                   d,
   input  logic                   q_in
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_e;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0] IDX_LAST    = 4'd15;

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  abcd_q, abcd_d;
   logic [15:0] table_q, table_d;
   logic        valid_q, valid_d;

   // abort beats start when both arrive in IDLE.
   logic start_accept;
   assign start_accept = (state_q == S_IDLE) && host.start && !host.abort;

`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
   logic [4:0] mcnt_q, mcnt_d;
   logic [3:0] first_q, first_d;
   logic       sample_differs;

   assign sample_differs = (q_in != host.exp_table[idx_q]);
`endif

   // --------------------------------------------------------------------------
   // FSM process 1: state register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM process 2: next-state logic
   // --------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_accept) state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (host.abort)                state_d = S_IDLE;
            else if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (host.abort)            state_d = S_IDLE;
            else if (idx_q == IDX_LAST) state_d = S_DONE;
            else                        state_d = S_SETTLE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM process 3: state-decoded outputs
   // --------------------------------------------------------------------------
   always_comb begin
      host.busy = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
      host.done = (state_q == S_DONE);
   end

   // --------------------------------------------------------------------------
   // Datapath next-state: vector index, settle counter, circuit drive, table
   // --------------------------------------------------------------------------
   always_comb begin
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      abcd_d  = abcd_q;
      table_d = table_q;
      valid_d = valid_q;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
      mcnt_d  = mcnt_q;
      first_d = first_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            abcd_d = 4'd0;
            if (start_accept) begin
               idx_d   = 4'd0;
               cnt_d   = 4'd0;
               table_d = 16'd0;
               valid_d = 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
               mcnt_d  = 5'd0;
               first_d = 4'd0;
`endif
            end
         end
         S_SETTLE: begin
            // The counter overshoots by one on the way into SAMPLE; it is
            // cleared again before the next vector starts settling.
            if (host.abort) abcd_d = 4'd0;
            else            cnt_d  = cnt_q + 4'd1;
         end
         S_SAMPLE: begin
            if (host.abort) begin
               // Abort takes priority over the pending sample; earlier
               // entries of the table are kept.
               abcd_d = 4'd0;
            end else begin
               table_d[idx_q] = q_in;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
               if (sample_differs) begin
                  mcnt_d = mcnt_q + 5'd1;
                  if (mcnt_q == 5'd0) first_d = idx_q;
               end
`endif
               if (idx_q == IDX_LAST) begin
                  abcd_d = 4'd0;
               end else begin
                  idx_d  = idx_q + 4'd1;
                  cnt_d  = 4'd0;
                  abcd_d = idx_q + 4'd1;
               end
            end
         end
         S_DONE: begin
            valid_d = 1'b1;
            abcd_d  = 4'd0;
         end
         default: abcd_d = 4'd0;
      endcase
   end

   // NOTE: all datapath registers, including the truth table, are reset so
   // the outputs read zero immediately when resetn falls.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idx_q   <= 4'd0;
         cnt_q   <= 4'd0;
         abcd_q  <= 4'd0;
         table_q <= 16'd0;
         valid_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         abcd_q  <= abcd_d;
         table_q <= table_d;
         valid_q <= valid_d;
      end
   end

`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mcnt_q  <= 5'd0;
         first_q <= 4'd0;
      end else begin
         mcnt_q  <= mcnt_d;
         first_q <= first_d;
      end
   end

   assign host.mismatch_cnt       = mcnt_q;
   assign host.first_mismatch_idx = first_q;
   assign host.match              = valid_q && (mcnt_q == 5'd0);
`endif

   assign {a, b, c, d}     = abcd_q;
   assign host.truth_table = table_q;
   assign host.valid       = valid_q;

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Drives directed sweeps into truth_table_sweeper. Each accepted sweep pushes
// its hand-computed expected result into a queue; an independent monitor pops
// and compares whenever the sweeper pulses done. The circuit under
// characterization is q = b|c (table 16'hFCFC) or q = a^d (table 16'h55AA).
// Compile with +define+TRUTH_TABLE_SWEEPER_COMPARE_EN to cover the compare
// outputs as well.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

   localparam int SETTLE = 2;
   localparam int VEC    = SETTLE + 1;      // cycles per vector

   logic clk;
   logic resetn;
   logic a, b, c, d;
   logic q_in;
   logic sel_xor;

   truth_table_sweeper_if host_if ();

   truth_table_sweeper #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk    (clk),
      .resetn (resetn),
      .host   (host_if),
      .a      (a),
      .b      (b),
      .c      (c),
      .d      (d),
      .q_in   (q_in)
   );

   // Circuit being characterized.
   assign q_in = sel_xor ? (a ^ d) : (b | c);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] table_v;
      int unsigned done_cyc;
      logic [4:0]  mcnt;
      logic [3:0]  first;
      logic        match;
   } exp_t;

   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Issue a start pulse; if the sweep is expected to complete, push its result.
   task automatic pulse_start(input bit expect_done, input logic [15:0] tt,
                              input logic [4:0] mcnt, input logic [3:0] first,
                              input logic match);
      exp_t e;
      @(negedge clk);
      host_if.start = 1'b1;
      if (expect_done) begin
         e.table_v  = tt;
         // start is seen at the next rising edge (cyc+1); done occupies the
         // cycle 16 vectors later, observed here at the following falling edge.
         e.done_cyc = cyc + 1 + 16 * VEC;
         e.mcnt     = mcnt;
         e.first    = first;
         e.match    = match;
         sb.push_back(e);
      end
      @(negedge clk);
      host_if.start = 1'b0;
   endtask

   // Wait (bounded) until the sweeper is driving vector v.
   task automatic wait_vector(input logic [3:0] v);
      bit found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if ({a, b, c, d} == v && host_if.busy) found = 1'b1;
         else @(negedge clk);
      end
      check("reach_vector", found, 1);
   endtask

   // Wait (bounded) until every expected sweep has been retired.
   task automatic wait_idle();
      bit found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !host_if.busy) found = 1'b1;
      end
      check("sweep_complete", found, 1);
      repeat (3) @(negedge clk);
   endtask

   // --------------------------------------------------------------------------
   // Monitor: retires one expectation per done pulse.
   // --------------------------------------------------------------------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resetn === 1'b1 && host_if.done === 1'b1) begin
            check("done_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("done_cycle",    cyc, e.done_cyc);
               check("table_at_done", host_if.truth_table, e.table_v);
               check("busy_at_done",  host_if.busy, 0);
               check("abcd_at_done",  {a, b, c, d}, 0);
               @(negedge clk);
               check("done_one_cycle", host_if.done, 0);
               check("valid_after",    host_if.valid, 1);
               check("busy_after",     host_if.busy, 0);
               check("table_after",    host_if.truth_table, e.table_v);
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
               check("match",              host_if.match, e.match);
               check("mismatch_cnt",       host_if.mismatch_cnt, e.mcnt);
               check("first_mismatch_idx", host_if.first_mismatch_idx, e.first);
`endif
            end
         end
      end
   end

   // Hard stop in case something never finishes.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // --------------------------------------------------------------------------
   // Stimulus
   // --------------------------------------------------------------------------
   initial begin
      host_if.start = 1'b0;
      host_if.abort = 1'b0;
      sel_xor       = 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
      host_if.exp_table = 16'hFCFC;
`endif
      resetn = 1'b1;
      #1 resetn = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state.
      check("rst_busy",  host_if.busy, 0);
      check("rst_done",  host_if.done, 0);
      check("rst_valid", host_if.valid, 0);
      check("rst_table", host_if.truth_table, 0);
      check("rst_abcd",  {a, b, c, d}, 0);
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
      check("rst_match", host_if.match, 0);
      check("rst_mcnt",  host_if.mismatch_cnt, 0);
      check("rst_first", host_if.first_mismatch_idx, 0);
`endif
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_abcd", {a, b, c, d}, 0);

      // Sweep 1: q=b|c with a cycle-by-cycle trace of the circuit inputs.
      pulse_start(1'b1, 16'hFCFC, 5'd0, 4'd0, 1'b1);
      for (int k = 0; k < 16 * VEC; k++) begin
         check("abcd_trace", {host_if.busy, a, b, c, d}, {1'b1, 4'(k / VEC)});
         @(negedge clk);
      end
      check("abcd_post_sweep", {a, b, c, d}, 0);
      wait_idle();
      check("abcd_idle_after", {a, b, c, d}, 0);

      // Sweep 2: second start while busy at vector 7 is ignored.
      pulse_start(1'b1, 16'hFCFC, 5'd0, 4'd0, 1'b1);
      check("valid_cleared_on_start", host_if.valid, 0);
      wait_vector(4'd7);
      host_if.start = 1'b1;
      @(negedge clk);
      host_if.start = 1'b0;
      wait_idle();

      // Sweep 3: different circuit, q=a^d.
      sel_xor = 1'b1;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
      host_if.exp_table = 16'h55AA;
`endif
      pulse_start(1'b1, 16'h55AA, 5'd0, 4'd0, 1'b1);
      wait_idle();
      sel_xor = 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
      host_if.exp_table = 16'hFCFC;
`endif

      // Abort at vector 5 (first settle cycle): entries 0..4 are kept.
      pulse_start(1'b0, 16'h0, 5'd0, 4'd0, 1'b0);
      wait_vector(4'd5);
      host_if.abort = 1'b1;
      @(negedge clk);
      host_if.abort = 1'b0;
      check("abort_busy",  host_if.busy, 0);
      check("abort_valid", host_if.valid, 0);
      check("abort_done",  host_if.done, 0);
      check("abort_abcd",  {a, b, c, d}, 0);
      check("abort_table", host_if.truth_table, 16'h001C);
      repeat (5) @(negedge clk);
      check("abort_stays_idle", host_if.busy, 0);

      // abort and start together in IDLE: no sweep.
      host_if.start = 1'b1;
      host_if.abort = 1'b1;
      @(negedge clk);
      host_if.start = 1'b0;
      host_if.abort = 1'b0;
      check("abort_beats_start", host_if.busy, 0);
      @(negedge clk);
      check("abort_beats_start_abcd", {a, b, c, d}, 0);

      // Full sweep after abort.
      pulse_start(1'b1, 16'hFCFC, 5'd0, 4'd0, 1'b1);
      wait_idle();

      // Reset mid-sweep at vector 9: outputs clear before any clock edge.
      pulse_start(1'b0, 16'h0, 5'd0, 4'd0, 1'b0);
      wait_vector(4'd9);
      #1 resetn = 1'b0;
      #1;
      check("midrst_busy",  host_if.busy, 0);
      check("midrst_done",  host_if.done, 0);
      check("midrst_valid", host_if.valid, 0);
      check("midrst_table", host_if.truth_table, 0);
      check("midrst_abcd",  {a, b, c, d}, 0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      pulse_start(1'b1, 16'hFCFC, 5'd0, 4'd0, 1'b1);
      wait_idle();

`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
      // Expected table differs from q=b|c only at index 0.
      host_if.exp_table = 16'hFCFD;
      pulse_start(1'b1, 16'hFCFC, 5'd1, 4'd0, 1'b0);
      wait_idle();
      // Four differences, lowest at index 2.
      host_if.exp_table = 16'hF0F0;
      pulse_start(1'b1, 16'hFCFC, 5'd4, 4'd2, 1'b0);
      wait_idle();
`endif

      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_truth_table_sweeper

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that characterizes a 4-input combinational circuit (inputs a,b,c,d; output q) by sweeping all 16 input combinations.
- Drives the circuit's inputs, waits a programmable settle time, samples q, and assembles a 16-bit truth table.
- Sits between a host/test controller (start/abort/done handshake) and the circuit under characterization.

Parameters:
- SETTLE_CYCLES, 2, cycles to hold each input vector before sampling q; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request a sweep; accepted only in IDLE
- abort  in  1  cancel an in-progress sweep
- a  out  1  circuit input, bit 3 of vector index
- b  out  1  circuit input, bit 2
- c  out  1  circuit input, bit 1
- d  out  1  circuit input, bit 0
- q_in  in  1  circuit output being characterized
- busy  out  1  high while sweeping (SETTLE/SAMPLE)
- done  out  1  one-cycle pulse on sweep completion
- valid  out  1  truth_table holds a complete sweep
- truth_table  out  16  bit i = q sampled with {a,b,c,d} = i

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, idx=0, settle count=0, {a,b,c,d}=0, busy=0, done=0, valid=0, truth_table=0. Applies immediately, including mid-sweep.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: {a,b,c,d}=0. start=1 -> SETTLE, idx=0, cnt=0, truth_table cleared to 0, valid cleared to 0.
- SETTLE: {a,b,c,d}=idx, registered. Increment cnt each cycle. When cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE: truth_table[idx] <= q_in.
  - idx==15 -> DONE.
  - Otherwise idx <= idx+1, cnt <= 0, -> SETTLE.
- DONE: done=1 for exactly this cycle, valid <= 1, {a,b,c,d} <= 0, -> IDLE.
- Timing: if start is accepted at edge T, each vector takes SETTLE_CYCLES+1 cycles, and done is high in cycle T+1+16*(SETTLE_CYCLES+1). With the default, that is T+49.
- busy=1 in SETTLE and SAMPLE only.
- start while busy or in DONE: ignored, with no effect on the current sweep.
- abort=1 in SETTLE/SAMPLE: next state IDLE. No done pulse; valid stays 0; partial truth_table retained; {a,b,c,d}=0.
- abort and start both high in IDLE: abort wins; no sweep starts.
- abort in IDLE or DONE: no effect.
- idx is 4 bits and never wraps during a sweep; the 15 -> DONE transition terminates the sweep.
- q_in is sampled only in SAMPLE; its value at all other times is ignored.

Optional Feature:
- Macro: TRUTH_TABLE_SWEEPER_COMPARE_EN.
- When defined, the block adds these ports:
  - exp_table in 16: expected truth table, must be stable from start to done.
  - match out 1
  - mismatch_cnt out 5
  - first_mismatch_idx out 4
- Compare behaviour when defined:
  - Each SAMPLE compares q_in with exp_table[idx] and increments mismatch_cnt on difference.
  - first_mismatch_idx records idx of the first difference in the sweep.
  - match = valid && mismatch_cnt==0.
  - All three outputs reset to 0 and clear on start acceptance.
- When undefined: these ports and this logic are absent; all other behaviour is identical.

Test Plan:
- Circuit q=b|c, SETTLE_CYCLES=2, pulse start -> done at T+49; truth_table=16'hFCFC; valid=1; busy low after done.
- Observe a,b,c,d during sweep -> each vector 0..15 held exactly 3 cycles in ascending order; 0 before and after the sweep.
- Pulse start again at idx=7 while busy -> no restart; done still at T+49; result 16'hFCFC.
- Assert abort while idx=5 -> IDLE next cycle; busy=0, valid=0, no done pulse, abcd=0; new start then sweeps fully.
- Drive resetn low mid-sweep (idx=9) -> all outputs 0 immediately, before any clock edge; after release, start gives a correct full sweep.
- COMPARE_EN, q=b|c:
  - exp_table=16'hFCFC -> match=1, mismatch_cnt=0.
  - exp_table=16'hFCFD -> match=0, mismatch_cnt=1, first_mismatch_idx=0.
